// File: rtl/gate_bist_pkg.sv
// Shared types and reference truth tables for the primitive-gate BIST checker.
// Truth-table bit index is {a,b}.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist_pattern_gen.sv
// Pattern index counter and settle timer driving the registered {a,b} stimulus.
// Latency: {a,b} follows the FSM's next state on the same edge; no backpressure.
module gate_bist_pattern_gen
  import gate_bist_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_start,
  input  logic step,
  input  logic applying,
  input  logic active_nxt,
  output logic a,
  output logic b,
  output logic settle_done,
  output logic last_pattern
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;

  assign settle_done  = applying && (cnt_q == SETTLE_LAST);
  assign last_pattern = (idx_q == 2'd3);

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (run_start) begin
      idx_d = 2'd0;
      cnt_d = 4'd0;
    end else if (step) begin
      idx_d = idx_q + 2'd1;
      cnt_d = 4'd0;
    end else if (applying && !settle_done) begin
      cnt_d = cnt_q + 4'd1;
    end
    // Stimulus is forced to 00 whenever the engine is not driving a pattern.
    ab_d = active_nxt ? idx_d : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      cnt_q <= 4'd0;
      ab_q  <= 2'b00;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ab_q  <= ab_d;
    end
  end

  assign a = ab_q[1];
  assign b = ab_q[0];

endmodule

// File: rtl/gate_bist_checker.sv
// BIST engine for one 2-input gate: applies all four patterns, checks y against TRUTH.
// Latency: 4*(SETTLE+1) cycles from start to done; start ignored while busy.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TT_AND,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_idx,
  output logic [2:0] fail_cnt
);

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [1:0] fail_idx_q, fail_idx_d;
  logic [2:0] fail_cnt_q, fail_cnt_d;

  logic run_start, step, active_nxt, applying;
  logic settle_done, last_pattern, mismatch;

  assign applying = (state_q == ST_APPLY);

  gate_bist_pattern_gen #(
    .SETTLE(SETTLE)
  ) u_pattern_gen (
    .clk         (clk),
    .rst         (rst),
    .run_start   (run_start),
    .step        (step),
    .applying    (applying),
    .active_nxt  (active_nxt),
    .a           (a),
    .b           (b),
    .settle_done (settle_done),
    .last_pattern(last_pattern)
  );

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    fail_cnt_d = fail_cnt_q;
    run_start  = 1'b0;
    step       = 1'b0;
    // {a,b} equals the pattern index throughout APPLY/CHECK.
    mismatch   = (y != TRUTH[{a, b}]);
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_APPLY;
          run_start  = 1'b1;
          pass_d     = 1'b0;
          fail_idx_d = 2'd0;
          fail_cnt_d = 3'd0;
        end
      end
      ST_APPLY: begin
        if (settle_done) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + 3'd1;
          if (fail_cnt_q == 3'd0) fail_idx_d = {a, b};
        end
        if (last_pattern) begin
          state_d = ST_DONE;
          pass_d  = (fail_cnt_d == 3'd0);
        end else begin
          state_d = ST_APPLY;
          step    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_nxt = (state_d == ST_APPLY) || (state_d == ST_CHECK);
    busy_d     = active_nxt;
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= 2'd0;
      fail_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench: an AND-table checker (SETTLE=2) against a switchable gate model and an
// XOR-table checker (SETTLE=1) against a good XOR gate, both checked every cycle.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;

  localparam int SG = 2;
  localparam int SX = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_g, start_x;
  logic [3:0] gate_tt;

  logic       a_g, b_g, y_g, busy_g, done_g, pass_g;
  logic [1:0] fidx_g;
  logic [2:0] fcnt_g;
  logic       a_x, b_x, y_x, busy_x, done_x, pass_x;
  logic [1:0] fidx_x;
  logic [2:0] fcnt_x;

  assign y_g = gate_tt[{a_g, b_g}];
  assign y_x = a_x ^ b_x;

  gate_bist_checker #(.TRUTH(TT_AND), .SETTLE(SG)) u_dut_and (
    .clk(clk), .rst(rst), .start(start_g), .a(a_g), .b(b_g), .y(y_g),
    .busy(busy_g), .done(done_g), .pass(pass_g), .fail_idx(fidx_g), .fail_cnt(fcnt_g)
  );

  gate_bist_checker #(.TRUTH(TT_XOR), .SETTLE(SX)) u_dut_xor (
    .clk(clk), .rst(rst), .start(start_x), .a(a_x), .b(b_x), .y(y_x),
    .busy(busy_x), .done(done_x), .pass(pass_x), .fail_idx(fidx_x), .fail_cnt(fcnt_x)
  );

  int errors = 0;
  int checks = 0;

  // Expected outputs after edge t of a run (t=0: idle since reset).
  // Result packing: {a,b,busy,done,pass,fail_idx[1:0],fail_cnt[2:0]}.
  function automatic logic [9:0] model(input int t, input int s,
                                       input logic [3:0] truth, input logic [3:0] gate);
    int         per = s + 1;
    int         n = 0;
    logic [1:0] fi = 2'd0;
    logic [1:0] ab = 2'd0;
    logic       bz = 1'b0, dn = 1'b0, ps = 1'b0;
    if (t == 0) return 10'd0;
    for (int p = 0; p < 4; p++) begin
      if (((p + 1) * per + 1 <= t) && (gate[p] != truth[p])) begin
        if (n == 0) fi = 2'(p);
        n++;
      end
    end
    if (t <= 4 * per) begin
      bz = 1'b1;
      ab = 2'((t - 1) / per);
    end else begin
      dn = 1'b1;
      ps = (n == 0);
    end
    return {ab, bz, dn, ps, fi, 3'(n)};
  endfunction

  int         t_g = 0, t_x = 0;
  logic [3:0] run_gate_g = 4'd0;
  bit         seen_edge = 1'b0;

  always @(posedge clk) begin
    seen_edge = 1'b1;
    if (rst) t_g = 0;
    else if (start_g && (t_g == 0 || t_g > 4 * (SG + 1))) begin
      t_g = 1;
      run_gate_g = gate_tt;
    end else if (t_g > 0) t_g++;
    if (rst) t_x = 0;
    else if (start_x && (t_x == 0 || t_x > 4 * (SX + 1))) t_x = 1;
    else if (t_x > 0) t_x++;
  end

  always @(negedge clk) begin
    logic [9:0] exp_v, act_v;
    if (seen_edge) begin
      exp_v = model(t_g, SG, TT_AND, run_gate_g);
      act_v = {a_g, b_g, busy_g, done_g, pass_g, fidx_g, fcnt_g};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_and t=%0d: got %b want %b", t_g, act_v, exp_v);
      end
      exp_v = model(t_x, SX, TT_XOR, 4'b0110);
      act_v = {a_x, b_x, busy_x, done_x, pass_x, fidx_x, fcnt_x};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_xor t=%0d: got %b want %b", t_x, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_val);
    checks++;
    if (act != exp_val) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start_g = 1'b0; start_x = 1'b0; gate_tt = TT_AND;
    tick(3);
    chk("reset_state_and", int'({a_g, b_g, busy_g, done_g, pass_g, fidx_g, fcnt_g}), 0);
    chk("reset_state_xor", int'({a_x, b_x, busy_x, done_x, pass_x, fidx_x, fcnt_x}), 0);
    rst = 1'b0;
    tick(1);

    // Good AND gate plus XOR run in parallel; extra start while busy at cycle 4.
    start_g = 1'b1; start_x = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (k == 1) begin start_g = 1'b0; start_x = 1'b0; end
      if (k == 4) start_g = 1'b1;
      if (k == 5) start_g = 1'b0;
      if (k == 1)  chk("ab_cycle1", int'({a_g, b_g, busy_g}), 3'b001);
      if (k == 4)  chk("ab_cycle4", int'({a_g, b_g}), 1);
      if (k == 7)  chk("ab_cycle7", int'({a_g, b_g}), 2);
      if (k == 10) chk("ab_cycle10", int'({a_g, b_g}), 3);
      if (k == 12) chk("and_done_edge12", int'(done_g), 0);
      if (k == 13) chk("and_done_edge13", int'({done_g, pass_g, fcnt_g, fidx_g}), 7'b1100000);
      if (k == 8)  chk("xor_done_edge8", int'({busy_x, done_x}), 2'b10);
      if (k == 9)  chk("xor_done_edge9", int'({busy_x, done_x, pass_x, fcnt_x}), 6'b011000);
    end

    // Stuck-at-0 output, started from DONE.
    gate_tt = 4'b0000; start_g = 1'b1;
    tick(1);
    start_g = 1'b0;
    chk("rerun_clears_done", int'({busy_g, done_g, pass_g}), 3'b100);
    tick(12);
    chk("stuck0_cnt", int'(fcnt_g), 1);
    chk("stuck0_idx", int'(fidx_g), 3);
    chk("stuck0_pass", int'({done_g, pass_g}), 2'b10);

    // OR gate in place of AND.
    gate_tt = TT_OR; start_g = 1'b1;
    tick(1);
    start_g = 1'b0;
    tick(12);
    chk("or_cnt", int'(fcnt_g), 2);
    chk("or_idx", int'(fidx_g), 1);
    chk("or_pass", int'({done_g, pass_g}), 2'b10);

    // Reset mid-run, then a clean rerun.
    gate_tt = TT_AND; start_g = 1'b1;
    tick(1);
    start_g = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrun_rst", int'({a_g, b_g, busy_g, done_g, fcnt_g}), 0);
    start_g = 1'b1;
    tick(1);
    start_g = 1'b0;
    tick(12);
    chk("after_rst_run", int'({done_g, pass_g, fcnt_g}), 5'b11000);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
